// File: rtl/kernel_loader_pkg.sv
// Shared definitions for the kernel loader: parameter defaults and the FSM state encoding.
package kernel_loader_pkg;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_DEPTH  = 27;
  localparam int DEF_ADDR_W = 24;
  localparam int LEN_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY,
    CHECK
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// WIDTH-bit modulo accumulator with synchronous clear and add-enable.
module loader_checksum #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) sum <= '0;
    else if (add)       sum <= sum + data;
  end

endmodule

// File: rtl/kernel_loader.sv
// Streams len words into data memory at base, reads them back and compares checksums.
module kernel_loader
  import kernel_loader_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WIDTH-1:0]  mem_wd,
  input  logic [WIDTH-1:0]  mem_rd,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t             state;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   len_r;
  logic [ADDR_W-1:0]  base_r;
  logic [ADDR_W:0]    end_addr;
  logic               range_bad;
  logic               launch;
  logic               accept;
  logic               rd_add;
  logic [WIDTH-1:0]   wr_sum;
  logic [WIDTH-1:0]   rd_sum;
  logic [WIDTH-1:0]   rd_next;

  assign end_addr  = {1'b0, base} + (ADDR_W+1)'(len);
  assign range_bad = end_addr > (ADDR_W+1)'(DEPTH);
  assign launch    = (state == IDLE) && start && (len != '0) && !range_bad;
  assign accept    = (state == LOAD) && s_valid && s_ready;
  assign rd_add    = (state == VERIFY);
  // The last read is folded in here so error can be registered together with done.
  assign rd_next   = rd_sum + mem_rd;

  loader_checksum #(.WIDTH(WIDTH)) u_wr_sum (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .add   (accept),
    .data  (s_data),
    .sum   (wr_sum)
  );

  loader_checksum #(.WIDTH(WIDTH)) u_rd_sum (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .add   (rd_add),
    .data  (mem_rd),
    .sum   (rd_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_wd  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      idx     <= '0;
      len_r   <= '0;
      base_r  <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done  <= 1'b1;
              error <= 1'b0;
            end else if (range_bad) begin
              done  <= 1'b1;
              error <= 1'b1;
            end else begin
              state   <= LOAD;
              s_ready <= 1'b1;
              busy    <= 1'b1;
              error   <= 1'b0;
              idx     <= '0;
              base_r  <= base;
              len_r   <= len;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we <= 1'b1;
            mem_a  <= base_r + ADDR_W'(idx);
            mem_wd <= s_data;
            idx    <= idx + 5'd1;
            if (idx == len_r - 5'd1) begin
              s_ready <= 1'b0;
              state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          idx   <= '0;
          mem_a <= base_r;
          state <= VERIFY;
        end
        VERIFY: begin
          idx   <= idx + 5'd1;
          mem_a <= base_r + ADDR_W'(idx + 5'd1);
          if (idx == len_r - 5'd1) begin
            state <= CHECK;
            done  <= 1'b1;
            error <= (wr_sum != rd_next);
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
